disp_rdmaster: RTL and testbench
================================

# disp_rdmaster

Parametrised AXI4 read master that fetches one display frame per start event from VRAM and streams it into the downstream pixel FIFO. It replaces the fixed-VGA, single-burst-in-flight display read controller. Resolution, pixel size, burst shape and outstanding-burst depth are generics. It adds a latched frame base, multiple bursts in flight, busy/frame-done status and optional overrun detection. It sits between the display timing block (AXISTART, DISPON, DISPADDR), the FIFO (FIFOREADY) and the AXI HP read port.

## Interface
- H_PIXELS, 640, active pixels per line
- V_LINES, 480, active lines per frame
- BYTES_PER_PIXEL, 2, bytes per pixel
- BURST_BEATS, 8, beats per burst (1..256); drives ARLEN
- BEAT_BYTES, 8, bytes per beat (bus width / 8)
- MAX_OUTSTANDING, 2, maximum bursts issued but not completed (1..15)
- ADDR_HI, 5'b10001, ARADDR[31:27]; fixes the window at 0x88000000–0x8FFFFFFF
- ACLK  in  1  single clock; all logic on rising edge
- ARST  in  1  synchronous, active-high reset
- ARADDR  out  32  {ADDR_HI, base + addrcnt}
- ARLEN  out  8  constant BURST_BEATS-1
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- RLAST  in  1  last beat of burst
- RVALID  in  1  read data valid
- RREADY  out  1  equals RVALID
- AXISTART  in  1  frame start request from another domain; rising edge is the event
- DISPON  in  1  display enable; qualifies start
- DISPADDR  in  27  frame base offset; sampled at accepted start
- FIFOREADY  in  1  FIFO has room for one more burst
- BUSY  out  1  high whenever state ≠ HALT
- FRAMEDONE  out  1  one-cycle pulse when the last burst of a frame has completed
- OVERRUN  out  1  sticky start-while-busy flag (see Configuration)

## Operation
- Derived constants:
  - FRAME_BYTES = H_PIXELS*V_LINES*BYTES_PER_PIXEL.
  - BURST_BYTES = BURST_BEATS*BEAT_BYTES.
  - FRAME_BYTES must be a nonzero multiple of BURST_BYTES and < 2^27. Violation is an elaboration error.
- Start detect: 3-flop synchroniser on AXISTART (ff[2:0]). dispstart = DISPON & (ff[2:1]==2'b01).
- addrcnt: 27-bit. Cleared and base latched from DISPADDR on an accepted start. Advances by BURST_BYTES on each AR handshake. The ARADDR[26:0] sum wraps modulo 2^27.
- outst counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on AR handshake.
  - -1 on R handshake with RLAST.
  - Both in the same cycle: unchanged.
  - RLAST beat at outst==0: ignored; the counter never underflows.
- issued_all = (addrcnt == FRAME_BYTES).
- States:
  - HALT: on dispstart, go to WAIT, clear addrcnt/outst and latch base; otherwise stay.
  - WAIT: if issued_all, go to DRAIN. Else, if FIFOREADY and outst < MAX_OUTSTANDING, go to ADDR. Else stay.
  - ADDR: ARVALID=1. ARADDR/ARLEN stay stable until ARREADY. On ARREADY, go to WAIT.
  - DRAIN: when outst==0 (including a decrement to 0 this cycle, i.e. next value), go to HALT and pulse FRAMEDONE.
- ARVALID is decoded from state==ADDR only. It never drops before ARREADY, and FIFOREADY falling while in ADDR does not withdraw it.
- dispstart while state ≠ HALT is ignored for fetch purposes.
- Reset mid-frame:
  - Immediate return to HALT; counters cleared.
  - In-flight R beats are still accepted (RREADY=RVALID) but are not counted.

## Timing
- Reset values: ARVALID=0, ARADDR={ADDR_HI,27'b0}, ARLEN=BURST_BEATS-1, RREADY=RVALID, BUSY=0, FRAMEDONE=0, OVERRUN=0. State HALT; addrcnt, base, outst and ff all 0.
- Start latency, with AXISTART rising before edge 1:
  - dispstart is high in the cycle after edge 2.
  - State is WAIT after edge 3.
  - ARVALID rises after edge 4, given FIFOREADY and DISPON held.
- Minimum AR spacing is 2 cycles (ADDR then WAIT). With ARREADY tied high, ARVALID is high every other cycle.
- FRAMEDONE is high for exactly the first cycle the state is HALT after DRAIN. BUSY falls on the same edge.
- A new start can be accepted in the cycle FRAMEDONE is high.

## Configuration
- DISP_OVERRUN_EN defined:
  - OVERRUN sets on the edge after any dispstart seen while state ≠ HALT.
  - It stays set until ARST.
  - It does not affect fetch.
- DISP_OVERRUN_EN undefined: OVERRUN is tied to 0 and no detection logic is built. Fetch behaviour is identical.

## Test plan
- Small frame: H=16, V=2, BPP=2, BURST_BEATS=4, BEAT_BYTES=8, DISPADDR=0x0001000, ARREADY=1, 4-beat responses -> exactly 2 ARs at 0x88001000 and 0x88001020, ARLEN=3; FRAMEDONE one pulse after the 2nd RLAST.
- Outstanding limit: MAX_OUTSTANDING=2, R channel stalled -> exactly 2 ARs, then ARVALID stays 0. Release one RLAST -> 3rd AR within 2 cycles.
- FIFO throttle: FIFOREADY=0 at start -> no ARVALID. FIFOREADY=1 -> ARVALID next cycle. FIFOREADY drops during ARVALID with ARREADY=0 -> ARVALID held.
- Base latch: change DISPADDR to 0x0100000 mid-frame -> remaining ARs continue from the original base; next frame uses 0x88100000.
- Overrun/reset: AXISTART pulse while BUSY -> no restart, OVERRUN=1 (0 without DISP_OVERRUN_EN). ARST mid-frame -> all outputs at reset values on the next cycle.
- Default params: 9600 ARs per frame, last ARADDR[26:0] = DISPADDR+614336, outst never exceeds 2.

Source files
------------

// File: rtl/disp_rdmaster_if.sv
// -----------------------------------------------------------------------------
// disp_rdmaster_if
// AXI4 read-address / read-data subset used by the display read master.
//   ARADDR  [31:0]  read address             (master -> slave)
//   ARLEN   [7:0]   burst length minus one   (master -> slave)
//   ARVALID         read address valid       (master -> slave)
//   ARREADY         read address ready       (slave  -> master)
//   RLAST           last beat of burst       (slave  -> master)
//   RVALID          read data valid          (slave  -> master)
//   RREADY          read data ready          (master -> slave)
// -----------------------------------------------------------------------------
interface disp_rdmaster_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RLAST, RVALID
    );
endinterface

// File: rtl/disp_rdmaster.sv
// -----------------------------------------------------------------------------
// disp_rdmaster
// AXI4 read master that fetches one display frame from VRAM per start event
// and streams it into the downstream pixel FIFO. Several bursts may be in
// flight (up to MAX_OUTSTANDING); the frame base is latched at start.
//
// Ports
//   ACLK       clock, all logic on the rising edge
//   ARST       synchronous active-high reset
//   axi        AXI read port (master modport of disp_rdmaster_if)
//   AXISTART   frame start request from another clock domain (rising edge)
//   DISPON     display enable, qualifies the start
//   DISPADDR   frame base offset [26:0], sampled at an accepted start
//   FIFOREADY  FIFO can take one more burst
//   BUSY       high whenever a frame fetch is in progress
//   FRAMEDONE  one-cycle pulse after the last burst of a frame completed
//   OVERRUN    sticky start-while-busy flag
//
// Optional feature: define DISP_OVERRUN_EN to build the overrun detector.
// Without it OVERRUN is constant 0 and fetch behaviour is unchanged.
// -----------------------------------------------------------------------------
module disp_rdmaster #(
    parameter int         H_PIXELS        = 640,
    parameter int         V_LINES         = 480,
    parameter int         BYTES_PER_PIXEL = 2,
    parameter int         BURST_BEATS     = 8,
    parameter int         BEAT_BYTES      = 8,
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [4:0] ADDR_HI         = 5'b10001
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    disp_rdmaster_if.master       axi,
    input  logic                  AXISTART,
    input  logic                  DISPON,
    input  logic [26:0]           DISPADDR,
    input  logic                  FIFOREADY,
    output logic                  BUSY,
    output logic                  FRAMEDONE,
    output logic                  OVERRUN
);

    localparam longint FRAME_BYTES = longint'(H_PIXELS) * longint'(V_LINES)
                                     * longint'(BYTES_PER_PIXEL);
    localparam longint BURST_BYTES = longint'(BURST_BEATS) * longint'(BEAT_BYTES);
    localparam int     OUTST_W     = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [26:0]        FRAME_END = 27'(FRAME_BYTES);
    localparam logic [26:0]        BURST_INC = 27'(BURST_BYTES);
    localparam logic [7:0]         ARLEN_C   = 8'(BURST_BEATS - 1);
    localparam logic [OUTST_W-1:0] MAX_OUT   = OUTST_W'(MAX_OUTSTANDING);

    // Parameter sanity: bad geometry must stop elaboration.
    generate
        if (BURST_BEATS < 1 || BURST_BEATS > 256) begin : g_bad_beats
            $error("disp_rdmaster: BURST_BEATS must be 1..256");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_outst
            $error("disp_rdmaster: MAX_OUTSTANDING must be 1..15");
        end
        if (BEAT_BYTES < 1) begin : g_bad_beat_bytes
            $error("disp_rdmaster: BEAT_BYTES must be positive");
        end
        else if (FRAME_BYTES <= 0 || FRAME_BYTES >= (64'sd1 << 27)
                 || (FRAME_BYTES % BURST_BYTES) != 0) begin : g_bad_frame
            $error("disp_rdmaster: frame size must be a nonzero multiple of the burst size below 2^27");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_HALT,
        S_WAIT,
        S_ADDR,
        S_DRAIN
    } state_t;

    state_t               state_reg, state_next;
    logic [2:0]           ff_reg;
    logic [26:0]          addrcnt_reg, addrcnt_next;
    logic [26:0]          base_reg, base_next;
    logic [OUTST_W-1:0]   outst_reg, outst_next;
    logic                 framedone_reg, framedone_next;

    logic dispstart;
    logic ar_hs;
    logic r_dec;
    logic issued_all;

    // ff_reg[0] is the metastability catcher; the edge is detected on [2:1].
    assign dispstart  = DISPON && (ff_reg[2:1] == 2'b01);
    assign ar_hs      = (state_reg == S_ADDR) && axi.ARREADY;
    // A last beat with nothing outstanding (e.g. left over from a reset
    // mid-frame) is swallowed so the counter cannot underflow.
    assign r_dec      = axi.RVALID && axi.RLAST && (outst_reg != '0);
    assign issued_all = (addrcnt_reg == FRAME_END);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_reg     <= S_HALT;
            ff_reg        <= 3'b000;
            addrcnt_reg   <= '0;
            base_reg      <= '0;
            outst_reg     <= '0;
            framedone_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ff_reg        <= {ff_reg[1:0], AXISTART};
            addrcnt_reg   <= addrcnt_next;
            base_reg      <= base_next;
            outst_reg     <= outst_next;
            framedone_reg <= framedone_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addrcnt_next   = addrcnt_reg;
        base_next      = base_reg;
        outst_next     = outst_reg;
        framedone_next = 1'b0;

        if (ar_hs) begin
            addrcnt_next = addrcnt_reg + BURST_INC;
        end

        // Issue and completion in the same cycle cancel out.
        if (ar_hs && !r_dec) begin
            outst_next = outst_reg + 1'b1;
        end else if (r_dec && !ar_hs) begin
            outst_next = outst_reg - 1'b1;
        end

        case (state_reg)
            S_HALT: begin
                if (dispstart) begin
                    state_next   = S_WAIT;
                    addrcnt_next = '0;
                    outst_next   = '0;
                    base_next    = DISPADDR;
                end
            end
            S_WAIT: begin
                if (issued_all) begin
                    state_next = S_DRAIN;
                end else if (FIFOREADY && (outst_reg < MAX_OUT)) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                // Once raised, ARVALID is held regardless of FIFOREADY.
                if (axi.ARREADY) begin
                    state_next = S_WAIT;
                end
            end
            S_DRAIN: begin
                // Look at the next count so the final RLAST ends the frame
                // without an extra idle cycle.
                if (outst_next == '0) begin
                    state_next     = S_HALT;
                    framedone_next = 1'b1;
                end
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    assign axi.ARVALID = (state_reg == S_ADDR);
    assign axi.ARADDR  = {ADDR_HI, base_reg + addrcnt_reg};
    assign axi.ARLEN   = ARLEN_C;
    assign axi.RREADY  = axi.RVALID;

    assign BUSY      = (state_reg != S_HALT);
    assign FRAMEDONE = framedone_reg;

`ifdef DISP_OVERRUN_EN
    logic overrun_reg;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            overrun_reg <= 1'b0;
        end else if (dispstart && (state_reg != S_HALT)) begin
            overrun_reg <= 1'b1;
        end
    end

    assign OVERRUN = overrun_reg;
`else
    assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_disp_rdmaster.sv
// -----------------------------------------------------------------------------
// tb_disp_rdmaster
// Two instances: a small-frame DUT (16x2x2 bytes, 4x8-byte bursts -> 2 ARs
// per frame) driven by a vector table plus hand sequences, and a default
// parameter DUT used for the outstanding limit and the full-frame count.
// -----------------------------------------------------------------------------
module tb_disp_rdmaster;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DISP_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    // ---------------- small-frame DUT ----------------
    logic        s_arst, s_axistart, s_dispon, s_fifo;
    logic [26:0] s_dispaddr;
    logic        s_busy, s_fd, s_ovr;
    disp_rdmaster_if ifc_s();

    disp_rdmaster #(
        .H_PIXELS(16), .V_LINES(2), .BYTES_PER_PIXEL(2),
        .BURST_BEATS(4), .BEAT_BYTES(8), .MAX_OUTSTANDING(2),
        .ADDR_HI(5'b10001)
    ) dut_s (
        .ACLK(ACLK), .ARST(s_arst), .axi(ifc_s),
        .AXISTART(s_axistart), .DISPON(s_dispon), .DISPADDR(s_dispaddr),
        .FIFOREADY(s_fifo), .BUSY(s_busy), .FRAMEDONE(s_fd), .OVERRUN(s_ovr)
    );

    // ---------------- default-parameter DUT ----------------
    logic        d_arst, d_axistart, d_dispon, d_fifo;
    logic [26:0] d_dispaddr;
    logic        d_busy, d_fd, d_ovr;
    disp_rdmaster_if ifc_d();

    disp_rdmaster dut_d (
        .ACLK(ACLK), .ARST(d_arst), .axi(ifc_d),
        .AXISTART(d_axistart), .DISPON(d_dispon), .DISPADDR(d_dispaddr),
        .FIFOREADY(d_fifo), .BUSY(d_busy), .FRAMEDONE(d_fd), .OVERRUN(d_ovr)
    );

    // ---------------- helpers ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Bench-side model of the default DUT's AXI traffic.
    int          ar_cnt, pend, max_pend;
    logic        seen_fd;
    logic [31:0] last_addr;

    task automatic d_cycle();
        logic hs, rl;
        hs = ifc_d.ARVALID && ifc_d.ARREADY;
        rl = ifc_d.RVALID && ifc_d.RLAST && (pend > 0);
        if (hs) last_addr = ifc_d.ARADDR;
        step();
        if (hs) ar_cnt++;
        if (hs) pend++;
        if (rl) pend--;
        if (pend > max_pend) max_pend = pend;
        if (d_fd) seen_fd = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        arst, ast, fifo, ardy, rv, rl;
        logic        exp_arv;
        logic [31:0] exp_addr;
        logic        exp_busy, exp_fd;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic [5:0] in, input logic arv,
                                input logic [31:0] a, input logic b, input logic f);
        vec_t v;
        v.arst = in[5]; v.ast = in[4]; v.fifo = in[3];
        v.ardy = in[2]; v.rv  = in[1]; v.rl   = in[0];
        v.exp_arv = arv; v.exp_addr = a; v.exp_busy = b; v.exp_fd = f;
        return v;
    endfunction

    logic bad, got;

    initial begin
        // inputs {arst, axistart, fifo, arready, rvalid, rlast}; outputs after the edge
        vecs[0]  = mk(6'b101100, 1'b0, 32'h88000000, 1'b0, 1'b0); // reset
        vecs[1]  = mk(6'b011100, 1'b0, 32'h88000000, 1'b0, 1'b0); // sync stage 0
        vecs[2]  = mk(6'b011100, 1'b0, 32'h88000000, 1'b0, 1'b0); // dispstart
        vecs[3]  = mk(6'b011100, 1'b0, 32'h88001000, 1'b1, 1'b0); // WAIT, base latched
        vecs[4]  = mk(6'b011100, 1'b1, 32'h88001000, 1'b1, 1'b0); // AR #1
        vecs[5]  = mk(6'b011100, 1'b0, 32'h88001020, 1'b1, 1'b0);
        vecs[6]  = mk(6'b011100, 1'b1, 32'h88001020, 1'b1, 1'b0); // AR #2
        vecs[7]  = mk(6'b011100, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[8]  = mk(6'b011100, 1'b0, 32'h88001040, 1'b1, 1'b0); // DRAIN
        vecs[9]  = mk(6'b011110, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[10] = mk(6'b011110, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[11] = mk(6'b011110, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[12] = mk(6'b011111, 1'b0, 32'h88001040, 1'b1, 1'b0); // RLAST #1
        vecs[13] = mk(6'b011110, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[14] = mk(6'b011110, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[15] = mk(6'b011110, 1'b0, 32'h88001040, 1'b1, 1'b0);
        vecs[16] = mk(6'b011111, 1'b0, 32'h88001040, 1'b0, 1'b1); // RLAST #2 -> done
        vecs[17] = mk(6'b011100, 1'b0, 32'h88001040, 1'b0, 1'b0);

        s_arst = 1'b1; s_axistart = 1'b0; s_dispon = 1'b1; s_fifo = 1'b1;
        s_dispaddr = 27'h0001000;
        ifc_s.ARREADY = 1'b0; ifc_s.RVALID = 1'b0; ifc_s.RLAST = 1'b0;
        d_arst = 1'b1; d_axistart = 1'b0; d_dispon = 1'b1; d_fifo = 1'b1;
        d_dispaddr = 27'h0000040;
        ifc_d.ARREADY = 1'b0; ifc_d.RVALID = 1'b0; ifc_d.RLAST = 1'b0;

        // ---- small frame, table driven ----
        for (int i = 0; i < NVEC; i++) begin
            s_arst = vecs[i].arst; s_axistart = vecs[i].ast; s_fifo = vecs[i].fifo;
            ifc_s.ARREADY = vecs[i].ardy; ifc_s.RVALID = vecs[i].rv; ifc_s.RLAST = vecs[i].rl;
            step();
            $display("vec %0d: arvalid=%b araddr=%08h busy=%b framedone=%b rready=%b",
                     i, ifc_s.ARVALID, ifc_s.ARADDR, s_busy, s_fd, ifc_s.RREADY);
            check1($sformatf("vec%0d_arvalid", i), ifc_s.ARVALID, vecs[i].exp_arv);
            check32($sformatf("vec%0d_araddr", i), ifc_s.ARADDR, vecs[i].exp_addr);
            check1($sformatf("vec%0d_busy", i), s_busy, vecs[i].exp_busy);
            check1($sformatf("vec%0d_framedone", i), s_fd, vecs[i].exp_fd);
            check1($sformatf("vec%0d_rready", i), ifc_s.RREADY, vecs[i].rv);
            if (i == 0) begin
                check32("reset_arlen", {24'b0, ifc_s.ARLEN}, 32'd3);
                check1("reset_overrun", s_ovr, 1'b0);
            end
        end

        // ---- FIFO throttle, base latch, overrun ----
        s_axistart = 1'b0; s_fifo = 1'b0; ifc_s.ARREADY = 1'b0; ifc_s.RVALID = 1'b0;
        step();
        s_axistart = 1'b1;
        step(); step(); step();
        check1("thr_busy", s_busy, 1'b1);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ifc_s.ARVALID) bad = 1'b1;
        end
        check1("thr_no_arvalid", bad, 1'b0);
        s_fifo = 1'b1;
        step();
        check1("thr_release", ifc_s.ARVALID, 1'b1);
        s_fifo = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (!ifc_s.ARVALID) bad = 1'b1;
        end
        check1("thr_held", bad, 1'b0);
        check32("thr_addr0", ifc_s.ARADDR, 32'h88001000);
        s_dispaddr = 27'h0100000; ifc_s.ARREADY = 1'b1;
        step();
        ifc_s.ARREADY = 1'b0;
        check1("ovr_before", s_ovr, 1'b0);
        s_axistart = 1'b0;
        step();
        s_axistart = 1'b1;
        step(); step(); step();
        $display("overrun pulse: overrun=%b busy=%b araddr=%08h", s_ovr, s_busy, ifc_s.ARADDR);
        check1("ovr_flag", s_ovr, OVR_EXP);
        check1("ovr_busy", s_busy, 1'b1);
        check32("base_kept", ifc_s.ARADDR, 32'h88001020);
        s_fifo = 1'b1; ifc_s.ARREADY = 1'b1;
        step();
        check1("ar2_valid", ifc_s.ARVALID, 1'b1);
        check32("ar2_addr", ifc_s.ARADDR, 32'h88001020);
        step();
        for (int b = 0; b < 8; b++) begin
            ifc_s.RVALID = 1'b1; ifc_s.RLAST = ((b % 4) == 3);
            step();
        end
        check1("fd_pulse", s_fd, 1'b1);
        check1("fd_busy", s_busy, 1'b0);
        ifc_s.RVALID = 1'b0; ifc_s.RLAST = 1'b0;
        step();
        check1("fd_once", s_fd, 1'b0);
        check1("ovr_sticky", s_ovr, OVR_EXP);

        // ---- next frame uses new base, then reset mid-frame ----
        s_axistart = 1'b0;
        step();
        s_axistart = 1'b1;
        step(); step(); step();
        check32("next_base", ifc_s.ARADDR, 32'h88100000);
        check1("next_busy", s_busy, 1'b1);
        step();
        check1("next_arvalid", ifc_s.ARVALID, 1'b1);
        s_arst = 1'b1; s_axistart = 1'b0;
        step();
        $display("reset mid-frame: arvalid=%b araddr=%08h busy=%b", ifc_s.ARVALID, ifc_s.ARADDR, s_busy);
        check1("rst_arvalid", ifc_s.ARVALID, 1'b0);
        check32("rst_araddr", ifc_s.ARADDR, 32'h88000000);
        check32("rst_arlen", {24'b0, ifc_s.ARLEN}, 32'd3);
        check1("rst_busy", s_busy, 1'b0);
        check1("rst_fd", s_fd, 1'b0);
        check1("rst_ovr", s_ovr, 1'b0);
        s_arst = 1'b0; ifc_s.RVALID = 1'b1; ifc_s.RLAST = 1'b1;
        step();
        check1("rst_rready", ifc_s.RREADY, 1'b1);
        check1("rst_idle", s_busy, 1'b0);
        check1("rst_no_ar", ifc_s.ARVALID, 1'b0);
        ifc_s.RVALID = 1'b0; ifc_s.RLAST = 1'b0;

        // ---- default parameters ----
        check1("d_reset_arvalid", ifc_d.ARVALID, 1'b0);
        check32("d_reset_araddr", ifc_d.ARADDR, 32'h88000000);
        check32("d_reset_arlen", {24'b0, ifc_d.ARLEN}, 32'd7);
        check1("d_reset_busy", d_busy, 1'b0);
        ar_cnt = 0; pend = 0; max_pend = 0; seen_fd = 1'b0; last_addr = '0;
        d_arst = 1'b0; ifc_d.ARREADY = 1'b1; d_axistart = 1'b1;
        for (int c = 0; c < 30; c++) d_cycle();
        $display("stalled R: ar_count=%0d arvalid=%b", ar_cnt, ifc_d.ARVALID);
        check32("stall_ar_count", ar_cnt, 32'd2);
        check1("stall_arvalid", ifc_d.ARVALID, 1'b0);
        ifc_d.RVALID = 1'b1; ifc_d.RLAST = 1'b1;
        d_cycle();
        ifc_d.RVALID = 1'b0; ifc_d.RLAST = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!got) begin
                d_cycle();
                if (ifc_d.ARVALID) got = 1'b1;
            end
        end
        check1("release_ar", got, 1'b1);
        for (int c = 0; c < 40000 && !seen_fd; c++) begin
            ifc_d.RVALID = (pend > 0);
            ifc_d.RLAST  = (pend > 0);
            d_cycle();
        end
        ifc_d.RVALID = 1'b0; ifc_d.RLAST = 1'b0;
        $display("full frame: ar_count=%0d last_araddr=%08h max_outstanding=%0d",
                 ar_cnt, last_addr, max_pend);
        check1("d_framedone_seen", seen_fd, 1'b1);
        check32("d_ar_count", ar_cnt, 32'd9600);
        check32("d_last_addr", last_addr, 32'h88096000);
        check1("d_max_outst", (max_pend <= 2), 1'b1);
        check1("d_busy_end", d_busy, 1'b0);
        check1("d_ovr", d_ovr, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
